// File: rtl/nor_or_pkg.sv
// ============================================================================
// Module      : nor_or_pkg
// Description : Shared types, constants and ideal-function helper for the
//               2-input NOR/OR gate block and its self-test checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nor_or_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } nor_or_state_t;

  localparam int unsigned NUM_VECTORS = 4;

  // Ideal gate response, packed as {nor, or}.
  function automatic logic [1:0] gate_expect(input logic a, input logic b);
    return {~(a | b), a | b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/nor_or_settle_timer.sv
// ============================================================================
// Module      : nor_or_settle_timer
// Description : Loadable down-counter with a zero flag; paces the settle time
//               between driving a gate vector and sampling its response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nor_or_settle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] r_count;

  // Load wins over decrement; the count parks at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count = r_count;
  assign zero  = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/nor_or_sweep_checker.sv
// ============================================================================
// Module      : nor_or_sweep_checker
// Description : On-board self-test engine that sweeps a NOR/OR gate through
//               all four input vectors and reports pass/fail and an error map.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nor_or_sweep_checker
  import nor_or_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       drive_a,
  output logic       drive_b,
  input  logic       y_nor_in,
  input  logic       y_or_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] err_vec
);

  localparam logic [CNT_W-1:0] c_settle_load = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
  localparam logic [1:0]       c_last_idx    = 2'(NUM_VECTORS - 1);
  localparam logic [2:0]       c_err_max     = 3'(NUM_VECTORS);

  nor_or_state_t r_state;
  logic [1:0]    r_idx;
  logic          r_drive_a;
  logic          r_drive_b;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic [2:0]    r_err_count;
  logic [3:0]    r_err_vec;

  logic             w_load;
  logic             w_dec;
  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_zero;
  logic [1:0]       w_exp;
  logic             w_mismatch;
  logic [1:0]       w_idx_next;
  logic [2:0]       w_err_count_next;

  nor_or_settle_timer #(
    .CNT_W (CNT_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (c_settle_load),
    .dec      (w_dec),
    .count    (w_cnt),
    .zero     (w_cnt_zero)
  );

  assign w_load     = (r_state == DRIVE);
  assign w_dec      = (r_state == SETTLE);
  assign w_exp      = gate_expect(r_drive_a, r_drive_b);
  // One vector scores a single error even when both outputs are wrong.
  assign w_mismatch = (y_nor_in != w_exp[1]) || (y_or_in != w_exp[0]);
  assign w_idx_next = r_idx + 2'd1;
  assign w_err_count_next = (w_mismatch && (r_err_count < c_err_max)) ?
                            r_err_count + 3'd1 : r_err_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= 2'd0;
      r_drive_a   <= 1'b0;
      r_drive_b   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= 3'd0;
      r_err_vec   <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_err_count <= 3'd0;
            r_err_vec   <= 4'd0;
            r_pass      <= 1'b0;
            r_idx       <= 2'd0;
            r_drive_a   <= 1'b0;
            r_drive_b   <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= DRIVE;
          end
        end

        DRIVE: begin
          if (SETTLE_CYCLES != 0) begin
            r_state <= SETTLE;
          end else begin
            r_state <= SAMPLE;
          end
        end

        // Leaving on a count of one gives exactly SETTLE_CYCLES cycles here;
        // the zero check only guards against a stuck counter.
        SETTLE: begin
          if (w_cnt_zero || (w_cnt == c_cnt_one)) begin
            r_state <= SAMPLE;
          end
        end

        SAMPLE: begin
          if (w_mismatch) begin
            r_err_vec[r_idx] <= 1'b1;
          end
          r_err_count <= w_err_count_next;
          if (r_idx == c_last_idx) begin
            r_done  <= 1'b1;
            r_pass  <= (w_err_count_next == 3'd0);
            r_state <= DONE;
          end else begin
            r_idx     <= w_idx_next;
            r_drive_a <= w_idx_next[1];
            r_drive_b <= w_idx_next[0];
            r_state   <= DRIVE;
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign drive_a   = r_drive_a;
  assign drive_b   = r_drive_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err_count;
  assign err_vec   = r_err_vec;

endmodule

`default_nettype wire

// File: tb/tb_nor_or_sweep_checker.sv
// ============================================================================
// Module      : tb_nor_or_sweep_checker
// Description : Self-checking bench for nor_or_sweep_checker with a faultable
//               behavioural gate on each of two checker instances.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nor_or_sweep_checker;

  typedef struct {
    int         mode;
    logic [3:0] vec;
    logic [2:0] cnt;
    logic       pss;
  } sweep_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   fault_mode = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_sel = 1'b0;

  // Instance 0: SETTLE_CYCLES=1; instance 1: SETTLE_CYCLES=0.
  logic start0 = 1'b0, start1 = 1'b0;
  logic drive_a0, drive_b0, busy0, done0, pass0, y_nor0, y_or0;
  logic drive_a1, drive_b1, busy1, done1, pass1, y_nor1, y_or1;
  logic [2:0] err_count0, err_count1;
  logic [3:0] err_vec0, err_vec1;

  logic [1:0] m_drive;
  logic       m_busy, m_done, m_pass;
  logic [2:0] m_cnt;
  logic [3:0] m_vec;

  sweep_vec_t tbl [6];

  always #5 clk = ~clk;

  // Reference gate: nor = ~(a|b), or = ~nor, then the selected fault.
  function automatic logic [1:0] gate_model(input logic a, input logic b, input int mode);
    logic n, o;
    n = ~(a | b);
    o = ~n;
    case (mode)
      1: o = 1'b0;
      2: if (a && !b) begin n = ~n; o = ~o; end
      3: n = 1'b1;
      4: if (a && b) o = ~o;
      5: n = ~n;
      default: ;
    endcase
    return {n, o};
  endfunction

  always_comb begin
    {y_nor0, y_or0} = gate_model(drive_a0, drive_b0, fault_mode);
    {y_nor1, y_or1} = gate_model(drive_a1, drive_b1, fault_mode);
  end

  always_comb begin
    m_drive = mon_sel ? {drive_a1, drive_b1} : {drive_a0, drive_b0};
    m_busy  = mon_sel ? busy1 : busy0;
    m_done  = mon_sel ? done1 : done0;
    m_pass  = mon_sel ? pass1 : pass0;
    m_cnt   = mon_sel ? err_count1 : err_count0;
    m_vec   = mon_sel ? err_vec1 : err_vec0;
  end

  nor_or_sweep_checker #(.SETTLE_CYCLES(1), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .drive_a(drive_a0), .drive_b(drive_b0),
    .y_nor_in(y_nor0), .y_or_in(y_or0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err_count0), .err_vec(err_vec0)
  );

  nor_or_sweep_checker #(.SETTLE_CYCLES(0), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .drive_a(drive_a1), .drive_b(drive_b1),
    .y_nor_in(y_nor1), .y_or_in(y_or1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err_count1), .err_vec(err_vec1)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start1 = v;
    else     start0 = v;
  endtask

  // Call at a negedge; returns at the negedge of the IDLE cycle after DONE.
  task automatic run_sweep(input bit sel, input int s, input bit poke, input logic exp_pass);
    int per;
    int done_cyc;
    per      = s + 2;
    done_cyc = 4 * per + 1;
    mon_sel  = sel;
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    for (int k = 1; k <= done_cyc + 1; k++) begin
      check($sformatf("s%0d drive c%0d", s, k), 32'(m_drive),
            (k <= 4 * per) ? 32'((k - 1) / per) : 32'd3);
      check($sformatf("s%0d busy c%0d", s, k), 32'(m_busy), 32'(k <= done_cyc));
      check($sformatf("s%0d done c%0d", s, k), 32'(m_done), 32'(k == done_cyc));
      if (k == 1) begin
        check("clear err_count", 32'(m_cnt), 32'd0);
        check("clear err_vec", 32'(m_vec), 32'd0);
        check("clear pass", 32'(m_pass), 32'd0);
      end
      if (k == done_cyc) check("pass in DONE", 32'(m_pass), 32'(exp_pass));
      set_start(sel, poke && (k == 3 || k == 7 || k == done_cyc));
      if (k <= done_cyc) @(negedge clk);
    end
    set_start(sel, 1'b0);
  endtask

  task automatic check_result(input string name, input logic [3:0] vec, input logic [2:0] cnt, input logic pss);
    check({name, " err_vec"}, 32'(m_vec), 32'(vec));
    check({name, " err_count"}, 32'(m_cnt), 32'(cnt));
    check({name, " pass"}, 32'(m_pass), 32'(pss));
  endtask

  initial begin
    tbl[0] = '{0, 4'b0000, 3'd0, 1'b1};
    tbl[1] = '{1, 4'b1110, 3'd3, 1'b0};
    tbl[2] = '{2, 4'b0100, 3'd1, 1'b0};
    tbl[3] = '{3, 4'b1110, 3'd3, 1'b0};
    tbl[4] = '{4, 4'b1000, 3'd1, 1'b0};
    tbl[5] = '{5, 4'b1111, 3'd4, 1'b0};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      mon_sel = bit'(i);
      check_result("reset", 4'b0000, 3'd0, 1'b0);
      check("reset busy", 32'(m_busy), 32'd0);
      check("reset done", 32'(m_done), 32'd0);
      check("reset drive", 32'(m_drive), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      fault_mode = tbl[i].mode;
      run_sweep(1'b0, 1, 1'b0, tbl[i].pss);
      check_result($sformatf("s1 mode%0d", tbl[i].mode), tbl[i].vec, tbl[i].cnt, tbl[i].pss);
    end

    for (int i = 0; i < 2; i++) begin
      fault_mode = tbl[i].mode;
      run_sweep(1'b1, 0, 1'b0, tbl[i].pss);
      check_result($sformatf("s0 mode%0d", tbl[i].mode), tbl[i].vec, tbl[i].cnt, tbl[i].pss);
    end

    // Starts during the sweep and in DONE are ignored; a start in the
    // following IDLE cycle begins a fresh sweep that clears old results.
    fault_mode = 1;
    run_sweep(1'b0, 1, 1'b1, 1'b0);
    check_result("poke", 4'b1110, 3'd3, 1'b0);
    fault_mode = 0;
    run_sweep(1'b0, 1, 1'b0, 1'b1);
    check_result("b2b", 4'b0000, 3'd0, 1'b1);

    // Mid-sweep reset at cycle 6 after one error has been recorded.
    fault_mode = 5;
    mon_sel = 1'b0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (5) @(negedge clk);
    check("pre-reset err_count", 32'(err_count0), 32'd1);
    check("pre-reset err_vec", 32'(err_vec0), 32'b0001);
    rst_n = 1'b0;
    @(negedge clk);
    check_result("mid reset", 4'b0000, 3'd0, 1'b0);
    check("mid reset busy", 32'(busy0), 32'd0);
    check("mid reset done", 32'(done0), 32'd0);
    check("mid reset drive", 32'({drive_a0, drive_b0}), 32'd0);
    rst_n = 1'b1;
    fault_mode = 0;
    @(negedge clk);
    run_sweep(1'b0, 1, 1'b0, 1'b1);
    check_result("after reset", 4'b0000, 3'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
